// File: rtl/ps2_scancode_decoder_if.sv
// Bundle of the PS/2 byte input, the key-event queue handshake and the
// keyboard status outputs. The decoder sits on the slave side. The keyboard
// receiver and the CPU/IO consumer sit on the master side.
interface ps2_scancode_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready;
    logic       overflow;
    logic       ovf_clear;
    logic       mod_shift;
    logic       mod_ctrl;
    logic       mod_alt;
    logic       bat_ok;

    modport master (
        output received_data, received_data_en, ev_ready, ovf_clear,
        input  ev_valid, ev_data, overflow, mod_shift, mod_ctrl, mod_alt, bat_ok
    );

    modport slave (
        input  received_data, received_data_en, ev_ready, ovf_clear,
        output ev_valid, ev_data, overflow, mod_shift, mod_ctrl, mod_alt, bat_ok
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder. It collapses E0/F0/E1 prefix sequences into
// single 10-bit key events {release, extended, code}. The events are queued
// in a first-word-fall-through FIFO. The decoder also tracks the live
// Shift/Ctrl/Alt state and the BAT-passed flag.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input logic                    CLOCK_50,
    input logic                    reset,
    ps2_scancode_decoder_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        SKIP_E1
    } state_t;

    state_t     state, state_n;
    logic [2:0] skip_cnt, skip_n;
    logic       emit;
    logic [9:0] emit_data;
    logic       bat_set;
    logic       fake_shift;

    logic       l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt;
    logic       overflow_q, bat_ok_q;

    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic       empty, full, push, pop, push_ok;

    // Extended 0x12/0x59 are the "fake shift" bytes that wrap PrtScr and similar keys.
    assign fake_shift = (bus.received_data == 8'h12) || (bus.received_data == 8'h59);

    // Decoder state register and Pause skip counter
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
        end
    end

    // Next-state decode; emits at most one event per received byte
    always_comb begin
        state_n   = state;
        skip_n    = skip_cnt;
        emit      = 1'b0;
        emit_data = '0;
        bat_set   = 1'b0;
        if (bus.received_data_en) begin
            case (state)
                IDLE: begin
                    case (bus.received_data)
                        8'hE0: state_n = GOT_E0;
                        8'hF0: state_n = GOT_F0;
                        8'hE1: begin
                            state_n = SKIP_E1;
                            skip_n  = 3'd7;
                        end
                        8'hAA: bat_set = 1'b1;
                        8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: begin
                            emit      = 1'b1;
                            emit_data = {2'b00, bus.received_data};
                        end
                    endcase
                end
                GOT_E0: begin
                    case (bus.received_data)
                        8'hF0: state_n = GOT_E0F0;
                        8'hE0: state_n = GOT_E0;
                        default: begin
                            state_n   = IDLE;
                            emit      = !fake_shift;
                            emit_data = {2'b01, bus.received_data};
                        end
                    endcase
                end
                GOT_F0: begin
                    if (bus.received_data == 8'hE0) begin
                        state_n = GOT_E0F0;
                    end else begin
                        state_n   = IDLE;
                        emit      = 1'b1;
                        emit_data = {2'b10, bus.received_data};
                    end
                end
                GOT_E0F0: begin
                    state_n   = IDLE;
                    emit      = !fake_shift;
                    emit_data = {2'b11, bus.received_data};
                end
                SKIP_E1: begin
                    if (skip_cnt <= 3'd1) begin
                        skip_n    = '0;
                        state_n   = IDLE;
                        emit      = 1'b1;
                        emit_data = {2'b00, 8'hE1};
                    end else begin
                        skip_n = skip_cnt - 3'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    skip_n  = '0;
                end
            endcase
        end
    end

    // Modifier bits follow decoded make/break events, whether or not the FIFO accepts them
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            l_shift <= 1'b0;
            r_shift <= 1'b0;
            l_ctrl  <= 1'b0;
            r_ctrl  <= 1'b0;
            l_alt   <= 1'b0;
            r_alt   <= 1'b0;
        end else if (emit) begin
            case (emit_data[8:0])
                {1'b0, 8'h12}: l_shift <= !emit_data[9];
                {1'b0, 8'h59}: r_shift <= !emit_data[9];
                {1'b0, 8'h14}: l_ctrl  <= !emit_data[9];
                {1'b1, 8'h14}: r_ctrl  <= !emit_data[9];
                {1'b0, 8'h11}: l_alt   <= !emit_data[9];
                {1'b1, 8'h11}: r_alt   <= !emit_data[9];
                default: ;
            endcase
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = bus.ev_ready && !empty;
    assign push    = emit;
    assign push_ok = push && (!full || pop);

    // FIFO pointers. A push into a full FIFO is accepted when a pop happens in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage, written on accepted pushes only
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= emit_data;
    end

    // Sticky flags. A new overflow takes priority over ovf_clear in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overflow_q <= 1'b0;
            bat_ok_q   <= 1'b0;
        end else begin
            if (push && !push_ok)   overflow_q <= 1'b1;
            else if (bus.ovf_clear) overflow_q <= 1'b0;
            if (bat_set) bat_ok_q <= 1'b1;
        end
    end

    assign bus.ev_valid  = !empty;
    assign bus.ev_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.overflow  = overflow_q;
    assign bus.bat_ok    = bat_ok_q;
    assign bus.mod_shift = l_shift | r_shift;
    assign bus.mod_ctrl  = l_ctrl | r_ctrl;
    assign bus.mod_alt   = l_alt | r_alt;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder. Expected events go into a scoreboard
// queue as bytes are driven, and are popped and compared as the FIFO drains.
module tb_ps2_scancode_decoder;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [9:0] exp_q[$];

    ps2_scancode_decoder_if bus();

    ps2_scancode_decoder #(.FIFO_DEPTH(8)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge, so consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
    endtask

    task automatic expect_ev(input logic [9:0] e);
        exp_q.push_back(e);
    endtask

    // Compare the FIFO head against the scoreboard, then pop it.
    task automatic pop_check(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, {31'd0, bus.ev_valid}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {31'd0, bus.ev_valid}, 32'd1);
            chk({tag, "_data"}, {22'd0, bus.ev_data}, {22'd0, e});
            bus.ev_ready = 1'b1;
            @(negedge clk);
            bus.ev_ready = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) pop_check(tag);
        chk({tag, "_empty_valid"}, {31'd0, bus.ev_valid}, 32'd0);
        chk({tag, "_empty_data"}, {22'd0, bus.ev_data}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.received_data    = '0;
        bus.received_data_en = 1'b0;
        bus.ev_ready         = 1'b0;
        bus.ovf_clear        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("rst_data", {22'd0, bus.ev_data}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("rst_mods", {29'd0, bus.mod_shift, bus.mod_ctrl, bus.mod_alt}, 32'd0);
        chk("rst_bat", {31'd0, bus.bat_ok}, 32'd0);

        // normal key, one-cycle latency
        send(8'h1C); expect_ev(10'h01C);
        chk("lat_valid", {31'd0, bus.ev_valid}, 32'd1);
        pop_check("make1c");
        send(8'hF0); send(8'h1C); expect_ev(10'h21C);
        drain("brk1c");

        // extended key make/break, back-to-back
        send(8'hE0); send(8'h75); expect_ev(10'h175);
        send(8'hE0); send(8'hF0); send(8'h75); expect_ev(10'h375);
        drain("ext75");

        // Pause gives one event, then normal decode resumes
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        expect_ev(10'h0E1);
        send(8'h1C); expect_ev(10'h01C);
        drain("pause");

        // shift pair
        send(8'h12); expect_ev(10'h012);
        chk("lshift_set", {31'd0, bus.mod_shift}, 32'd1);
        send(8'h59); expect_ev(10'h059);
        send(8'hF0); send(8'h12); expect_ev(10'h212);
        chk("rshift_held", {31'd0, bus.mod_shift}, 32'd1);
        send(8'hF0); send(8'h59); expect_ev(10'h259);
        chk("shift_clr", {31'd0, bus.mod_shift}, 32'd0);
        drain("shift");

        // fake shifts around PrtScr
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C); expect_ev(10'h17C);
        chk("prtscr_shift0", {31'd0, bus.mod_shift}, 32'd0);
        send(8'h12); expect_ev(10'h012);
        send(8'hE0); send(8'hF0); send(8'h7C); expect_ev(10'h37C);
        send(8'hE0); send(8'hF0); send(8'h12);
        chk("fake_brk_shift1", {31'd0, bus.mod_shift}, 32'd1);
        send(8'hF0); send(8'h12); expect_ev(10'h212);
        drain("prtscr");

        // ctrl and alt
        send(8'hE0); send(8'h14); expect_ev(10'h114);
        chk("rctrl_set", {31'd0, bus.mod_ctrl}, 32'd1);
        send(8'h11); expect_ev(10'h011);
        chk("lalt_set", {31'd0, bus.mod_alt}, 32'd1);
        send(8'hE0); send(8'hF0); send(8'h14); expect_ev(10'h314);
        chk("rctrl_clr", {31'd0, bus.mod_ctrl}, 32'd0);
        send(8'hF0); send(8'h11); expect_ev(10'h211);
        chk("lalt_clr", {31'd0, bus.mod_alt}, 32'd0);
        drain("ctrlalt");

        // overflow on the ninth event
        for (int unsigned i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i <= 8) expect_ev(10'(i));
        end
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        drain("ovf_drain");
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clear = 1'b1;
        @(negedge clk);
        bus.ovf_clear = 1'b0;
        chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);

        // set wins over clear, then push and pop together while full
        for (int unsigned i = 0; i < 8; i++) begin
            send(8'h21 + 8'(i));
            expect_ev(10'h021 + 10'(i));
        end
        chk("full_no_ovf", {31'd0, bus.overflow}, 32'd0);
        bus.ovf_clear = 1'b1;
        send(8'h30);
        bus.ovf_clear = 1'b0;
        chk("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
        bus.ovf_clear = 1'b1;
        @(negedge clk);
        bus.ovf_clear = 1'b0;
        chk("ovf_clr2", {31'd0, bus.overflow}, 32'd0);
        chk("full_head", {22'd0, bus.ev_data}, {22'd0, exp_q.pop_front()});
        bus.ev_ready = 1'b1;
        send(8'h29); expect_ev(10'h029);
        bus.ev_ready = 1'b0;
        chk("pushpop_no_ovf", {31'd0, bus.overflow}, 32'd0);
        drain("pushpop");

        // BAT and discarded bytes
        send(8'h12); expect_ev(10'h012);
        drain("pre_bat");
        send(8'hAA);
        chk("bat_set", {31'd0, bus.bat_ok}, 32'd1);
        chk("bat_no_ev", {31'd0, bus.ev_valid}, 32'd0);
        send(8'hFA);
        chk("ack_no_ev", {31'd0, bus.ev_valid}, 32'd0);

        // reset abandons a pending E0 and ignores a strobe in the reset cycle
        send(8'hE0);
        rst = 1'b1;
        bus.received_data    = 8'h1C;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
        rst = 1'b0;
        chk("rst2_bat", {31'd0, bus.bat_ok}, 32'd0);
        chk("rst2_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("rst2_data", {22'd0, bus.ev_data}, 32'd0);
        chk("rst2_mods", {29'd0, bus.mod_shift, bus.mod_ctrl, bus.mod_alt}, 32'd0);
        chk("rst2_ovf", {31'd0, bus.overflow}, 32'd0);
        send(8'h75); expect_ev(10'h075);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
